gray_ptr_ctrl: RTL and testbench
================================

// Module: gray_ptr_ctrl
// PURPOSE
//  FIFO pointer controller with a registered (ADDR_W+1)-bit binary/Gray pointer; the extra MSB is the wrap bit.
//  Takes the peer side's Gray pointer through optional pipeline stages and decodes it to binary.
//  Produces the full flag (write side) or empty flag (read side), plus almost flag, fill level and sticky error.
//  One instance per FIFO side; a write side and a read side together form the sync_fifo control path.
// PARAMETERS
//  ADDR_W      4  address width, FIFO depth = 2**ADDR_W; legal ADDR_W >= 2
//  MODE        0  0 = write side (flag = full), 1 = read side (flag = empty)
//  SYNC_STAGES 0  register stages on peer_gray_i, 0..3
//  ALMOST_TH   1  almost threshold in entries, 0..2**ADDR_W-1
// PORTS
//  clk_i        in   1         clock, rising edge
//  rst_i        in   1         reset, asynchronous, active-high
//  inc_i        in   1         advance-pointer request (push if MODE0, pop if MODE1)
//  clr_i        in   1         synchronous clear of pointer and error
//  peer_gray_i  in   ADDR_W+1  peer side's Gray pointer
//  inc_ok_o     out  1         request accepted this cycle (combinational)
//  ptr_bin_o    out  ADDR_W+1  binary pointer, registered
//  ptr_gray_o   out  ADDR_W+1  Gray pointer, registered
//  addr_o       out  ADDR_W    RAM address = ptr_bin_o[ADDR_W-1:0]
//  flag_o       out  1         full (MODE0) or empty (MODE1)
//  almost_o     out  1         almost-full (MODE0) or almost-empty (MODE1)
//  level_o      out  ADDR_W+1  entries held, 0..2**ADDR_W
//  ovf_err_o    out  1         sticky: request made while flag_o was set
// BEHAVIOUR
//  Reset:
//   - rst_i=1 forces ptr_bin, ptr_gray, all peer stages and ovf_err to 0 at once, no clock edge needed.
//   - After reset: level_o=0, almost_o per threshold; flag_o=0 in MODE0, flag_o=1 in MODE1.
//  Gray encoding: g[W]=b[W]; g[i]=b[i]^b[i+1] for i<W (W=ADDR_W).
//  Gray decoding: b[W]=g[W]; b[i]=b[i+1]^g[i], evaluated from MSB down.
//  Accept and advance:
//   - accept = inc_i & ~flag_o & ~clr_i; inc_ok_o = accept.
//   - On accept, ptr_bin <= ptr_bin+1, modulo 2**(ADDR_W+1).
//   - ptr_gray <= enc(ptr_bin+1) on the same edge: zero extra latency between the two pointers.
//  Wrap: 2**(ADDR_W+1)-1 -> 0; ptr_gray changes exactly one bit on every advance, including the wrap.
//  Clear: clr_i has priority over inc_i; on the edge, ptr_bin <= 0, ptr_gray <= 0, ovf_err <= 0.
//  Peer path:
//   - peer_gray_i passes through SYNC_STAGES registers, giving pg; SYNC_STAGES=0 means pg is combinational.
//   - pb = dec(pg).
//  Level (mod 2**(ADDR_W+1)): MODE0 level = ptr_bin - pb; MODE1 level = pb - ptr_bin.
//  Flags:
//   - MODE0 full:  ptr_gray == {~pg[W], ~pg[W-1], pg[W-2:0]}; equivalent to level == 2**ADDR_W.
//   - MODE1 empty: ptr_gray == pg.
//   - almost: MODE0 level >= 2**ADDR_W - ALMOST_TH; MODE1 level <= ALMOST_TH.
//   - flag_o, almost_o and level_o depend only on registers, plus peer_gray_i only when SYNC_STAGES=0.
//   - They reflect a pointer advance in the cycle after the advancing edge.
//  Error: ovf_err <= 1 on an edge with inc_i & flag_o & ~clr_i. Cleared only by rst_i or clr_i.
//  Simultaneous events:
//   - Own advance and peer change in the same cycle are both applied; flags recompute from the new state.
//   - An inc_i in the cycle flag_o rises is evaluated against the registered flag, so it is rejected.
// TESTING
//  T1 async reset: MODE0, advance to ptr 5, pulse rst_i between clock edges -> ptr_bin_o/ptr_gray_o = 0 before next edge.
//  T2 full: MODE0 ADDR_W=4, peer_gray_i=0, 16 incs -> ptr_bin 0x10, ptr_gray 0x18, level 16, flag_o=1;
//     17th inc -> inc_ok_o=0, pointer held, ovf_err_o=1.
//  T3 wrap: MODE0, peer tracks ptr-4 (enc'd), 40 incs -> ptr_bin 0x1F->0x00 with ptr_gray 0x10->0x00;
//     single-bit Gray change checked every step.
//  T4 read side: MODE1 SYNC_STAGES=2, peer_gray_i 0 -> 0x02 (bin 3) -> flag_o=1 until after 2nd edge, then level 3;
//     3 incs -> flag_o=1, level 0.
//  T5 clear priority: MODE0 ptr 7, ovf_err=1, clr_i=1 with inc_i=1 -> next cycle ptr 0, ovf_err_o=0, inc_ok_o=0.
//  T6 almost: MODE0 ALMOST_TH=1 -> almost_o=0 at level 14, 1 at levels 15 and 16; MODE1 -> almost_o=1 at level <=1.

Source files
------------

// File: rtl/gray_ptr_ctrl.sv
// FIFO pointer controller: binary/Gray pointer with wrap bit, peer pointer
// synchroniser and decoder, full/empty, almost, level and sticky error.
module gray_ptr_ctrl #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned MODE        = 0,
  parameter int unsigned SYNC_STAGES = 0,
  parameter int unsigned ALMOST_TH   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inc_i,
  input  logic              clr_i,
  input  logic [ADDR_W:0]   peer_gray_i,
  output logic              inc_ok_o,
  output logic [ADDR_W:0]   ptr_bin_o,
  output logic [ADDR_W:0]   ptr_gray_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              flag_o,
  output logic              almost_o,
  output logic [ADDR_W:0]   level_o,
  output logic              ovf_err_o
);

  localparam int unsigned PW    = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [PW-1:0] ALMOST_FULL_LVL  = PW'(DEPTH - ALMOST_TH);
  localparam logic [PW-1:0] ALMOST_EMPTY_LVL = PW'(ALMOST_TH);

  function automatic logic [PW-1:0] gray_enc(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray_dec(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = int'(PW) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] ptr_bin_q, ptr_bin_d;
  logic [PW-1:0] ptr_gray_q, ptr_gray_d;
  logic          ovf_err_q, ovf_err_d;
  logic [PW-1:0] pg, pb, ptr_inc, level;
  logic          flag, almost, accept;

  // Peer pointer pipeline; zero stages leaves the path combinational
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign pg = peer_gray_i;
    end else begin : g_sync
      logic [PW-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= peer_gray_i;
          for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign pg = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign pb = gray_dec(pg);

  generate
    if (MODE == 0) begin : g_wr
      assign level  = ptr_bin_q - pb;
      assign flag   = (ptr_gray_q == {~pg[ADDR_W], ~pg[ADDR_W-1], pg[ADDR_W-2:0]});
      assign almost = (level >= ALMOST_FULL_LVL);
    end else begin : g_rd
      assign level  = pb - ptr_bin_q;
      assign flag   = (ptr_gray_q == pg);
      assign almost = (level <= ALMOST_EMPTY_LVL);
    end
  endgenerate

  assign accept  = inc_i & ~flag & ~clr_i;
  assign ptr_inc = ptr_bin_q + PW'(1);

  // Next pointer and error state; clear wins over advance
  always_comb begin
    ptr_bin_d  = ptr_bin_q;
    ptr_gray_d = ptr_gray_q;
    ovf_err_d  = ovf_err_q;
    if (clr_i) begin
      ptr_bin_d  = '0;
      ptr_gray_d = '0;
      ovf_err_d  = 1'b0;
    end else begin
      if (accept) begin
        ptr_bin_d  = ptr_inc;
        ptr_gray_d = gray_enc(ptr_inc);
      end
      if (inc_i && flag) ovf_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_bin_q  <= '0;
      ptr_gray_q <= '0;
      ovf_err_q  <= 1'b0;
    end else begin
      ptr_bin_q  <= ptr_bin_d;
      ptr_gray_q <= ptr_gray_d;
      ovf_err_q  <= ovf_err_d;
    end
  end

  assign inc_ok_o   = accept;
  assign ptr_bin_o  = ptr_bin_q;
  assign ptr_gray_o = ptr_gray_q;
  assign addr_o     = ptr_bin_q[ADDR_W-1:0];
  assign flag_o     = flag;
  assign almost_o   = almost;
  assign level_o    = level;
  assign ovf_err_o  = ovf_err_q;

endmodule

// File: tb/tb_gray_ptr_ctrl.sv
// Directed bench for gray_ptr_ctrl: a write-side instance (no sync stages)
// and a read-side instance (two sync stages) sharing clock and reset.
module tb_gray_ptr_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       w_inc = 1'b0, w_clr = 1'b0;
  logic [4:0] w_peer = '0;
  logic       w_inc_ok, w_flag, w_almost, w_ovf;
  logic [4:0] w_bin, w_gray, w_level;
  logic [3:0] w_addr;
  logic       r_inc = 1'b0, r_clr = 1'b0;
  logic [4:0] r_peer = '0;
  logic       r_inc_ok, r_flag, r_almost, r_ovf;
  logic [4:0] r_bin, r_gray, r_level;
  logic [3:0] r_addr;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  gray_ptr_ctrl #(.ADDR_W(4), .MODE(0), .SYNC_STAGES(0), .ALMOST_TH(1)) u_w (
    .clk_i(clk), .rst_i(rst), .inc_i(w_inc), .clr_i(w_clr), .peer_gray_i(w_peer),
    .inc_ok_o(w_inc_ok), .ptr_bin_o(w_bin), .ptr_gray_o(w_gray), .addr_o(w_addr),
    .flag_o(w_flag), .almost_o(w_almost), .level_o(w_level), .ovf_err_o(w_ovf)
  );

  gray_ptr_ctrl #(.ADDR_W(4), .MODE(1), .SYNC_STAGES(2), .ALMOST_TH(1)) u_r (
    .clk_i(clk), .rst_i(rst), .inc_i(r_inc), .clr_i(r_clr), .peer_gray_i(r_peer),
    .inc_ok_o(r_inc_ok), .ptr_bin_o(r_bin), .ptr_gray_o(r_gray), .addr_o(r_addr),
    .flag_o(r_flag), .almost_o(r_almost), .level_o(r_level), .ovf_err_o(r_ovf)
  );

  // Bit-by-bit Gray encoding used to build peer pointer stimulus
  function automatic logic [4:0] enc5(input logic [4:0] b);
    logic [4:0] g;
    g[4] = b[4];
    for (int i = 0; i < 4; i++) g[i] = b[i] ^ b[i+1];
    return g;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vecs++; if (w_bin !== 5'h00)   begin errs++; $display("FAIL reset_w_bin: got %h expected 00", w_bin); end
    vecs++; if (w_gray !== 5'h00)  begin errs++; $display("FAIL reset_w_gray: got %h expected 00", w_gray); end
    vecs++; if (w_level !== 5'd0)  begin errs++; $display("FAIL reset_w_level: got %0d expected 0", w_level); end
    vecs++; if (w_flag !== 1'b0)   begin errs++; $display("FAIL reset_w_flag: got %b expected 0", w_flag); end
    vecs++; if (w_almost !== 1'b0) begin errs++; $display("FAIL reset_w_almost: got %b expected 0", w_almost); end
    vecs++; if (w_ovf !== 1'b0)    begin errs++; $display("FAIL reset_w_ovf: got %b expected 0", w_ovf); end
    vecs++; if (r_flag !== 1'b1)   begin errs++; $display("FAIL reset_r_flag: got %b expected 1", r_flag); end
    vecs++; if (r_almost !== 1'b1) begin errs++; $display("FAIL reset_r_almost: got %b expected 1", r_almost); end
    vecs++; if (r_level !== 5'd0)  begin errs++; $display("FAIL reset_r_level: got %0d expected 0", r_level); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    w_peer = 5'h00;
    w_inc  = 1'b1;
    repeat (5) tick();
    w_inc = 1'b0;
    vecs++; if (w_bin !== 5'h05)  begin errs++; $display("FAIL async_pre_bin: got %h expected 05", w_bin); end
    vecs++; if (w_gray !== 5'h07) begin errs++; $display("FAIL async_pre_gray: got %h expected 07", w_gray); end
    vecs++; if (w_addr !== 4'h5)  begin errs++; $display("FAIL async_pre_addr: got %h expected 5", w_addr); end
    #2 rst = 1'b1;
    #1;
    vecs++; if (w_bin !== 5'h00)  begin errs++; $display("FAIL async_bin: got %h expected 00", w_bin); end
    vecs++; if (w_gray !== 5'h00) begin errs++; $display("FAIL async_gray: got %h expected 00", w_gray); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_almost();
    w_peer = 5'h00;
    for (int k = 1; k <= 16; k++) begin
      w_inc = 1'b1;
      #1;
      vecs++; if (w_inc_ok !== 1'b1) begin errs++; $display("FAIL full_inc_ok_%0d: got %b expected 1", k, w_inc_ok); end
      tick();
      vecs++; if (w_level !== 5'(k)) begin errs++; $display("FAIL full_level_%0d: got %0d expected %0d", k, w_level, k); end
      if (k == 14) begin
        vecs++; if (w_almost !== 1'b0) begin errs++; $display("FAIL almost_lvl14: got %b expected 0", w_almost); end
      end
      if (k == 15) begin
        vecs++; if (w_almost !== 1'b1) begin errs++; $display("FAIL almost_lvl15: got %b expected 1", w_almost); end
        vecs++; if (w_flag !== 1'b0)   begin errs++; $display("FAIL full_lvl15_flag: got %b expected 0", w_flag); end
      end
    end
    w_inc = 1'b0;
    vecs++; if (w_bin !== 5'h10)   begin errs++; $display("FAIL full_bin: got %h expected 10", w_bin); end
    vecs++; if (w_gray !== 5'h18)  begin errs++; $display("FAIL full_gray: got %h expected 18", w_gray); end
    vecs++; if (w_flag !== 1'b1)   begin errs++; $display("FAIL full_flag: got %b expected 1", w_flag); end
    vecs++; if (w_almost !== 1'b1) begin errs++; $display("FAIL almost_lvl16: got %b expected 1", w_almost); end
    vecs++; if (w_ovf !== 1'b0)    begin errs++; $display("FAIL full_ovf_pre: got %b expected 0", w_ovf); end
    w_inc = 1'b1;
    #1;
    vecs++; if (w_inc_ok !== 1'b0) begin errs++; $display("FAIL full_17th_inc_ok: got %b expected 0", w_inc_ok); end
    tick();
    w_inc = 1'b0;
    vecs++; if (w_bin !== 5'h10) begin errs++; $display("FAIL full_17th_hold: got %h expected 10", w_bin); end
    vecs++; if (w_ovf !== 1'b1)  begin errs++; $display("FAIL full_ovf: got %b expected 1", w_ovf); end
  endtask

  task automatic test_clear_priority();
    w_clr = 1'b1;
    tick();
    w_clr = 1'b0;
    w_peer = 5'h00;
    vecs++; if (w_ovf !== 1'b0) begin errs++; $display("FAIL clr_ovf_first: got %b expected 0", w_ovf); end
    w_inc = 1'b1;
    repeat (7) tick();
    w_inc = 1'b0;
    vecs++; if (w_bin !== 5'h07) begin errs++; $display("FAIL clr_setup_bin: got %h expected 07", w_bin); end
    // Peer binary 0x17 puts a pointer of 7 exactly one depth ahead
    w_peer = 5'h1C;
    #1;
    vecs++; if (w_flag !== 1'b1) begin errs++; $display("FAIL clr_setup_flag: got %b expected 1", w_flag); end
    w_inc = 1'b1;
    tick();
    vecs++; if (w_ovf !== 1'b1) begin errs++; $display("FAIL clr_setup_ovf: got %b expected 1", w_ovf); end
    w_clr = 1'b1;
    #1;
    vecs++; if (w_inc_ok !== 1'b0) begin errs++; $display("FAIL clr_inc_ok: got %b expected 0", w_inc_ok); end
    tick();
    w_clr = 1'b0;
    w_inc = 1'b0;
    vecs++; if (w_bin !== 5'h00)  begin errs++; $display("FAIL clr_bin: got %h expected 00", w_bin); end
    vecs++; if (w_gray !== 5'h00) begin errs++; $display("FAIL clr_gray: got %h expected 00", w_gray); end
    vecs++; if (w_ovf !== 1'b0)   begin errs++; $display("FAIL clr_ovf: got %b expected 0", w_ovf); end
  endtask

  task automatic test_wrap();
    logic [4:0] exp_bin;
    logic [4:0] prev_gray;
    exp_bin   = 5'h00;
    prev_gray = w_gray;
    for (int k = 0; k < 40; k++) begin
      w_peer = enc5(exp_bin - 5'd4);
      w_inc  = 1'b1;
      #1;
      vecs++; if (w_inc_ok !== 1'b1) begin errs++; $display("FAIL wrap_inc_ok_%0d: got %b expected 1", k, w_inc_ok); end
      tick();
      exp_bin = exp_bin + 5'd1;
      vecs++; if (w_bin !== exp_bin) begin errs++; $display("FAIL wrap_bin_%0d: got %h expected %h", k, w_bin, exp_bin); end
      vecs++; if ($countones(w_gray ^ prev_gray) != 1) begin errs++; $display("FAIL wrap_gray_step_%0d: got %h after %h expected one bit change", k, w_gray, prev_gray); end
      if (exp_bin == 5'h00) begin
        vecs++; if (prev_gray !== 5'h10) begin errs++; $display("FAIL wrap_gray_before: got %h expected 10", prev_gray); end
        vecs++; if (w_gray !== 5'h00)    begin errs++; $display("FAIL wrap_gray_after: got %h expected 00", w_gray); end
      end
      prev_gray = w_gray;
    end
    w_inc = 1'b0;
    vecs++; if (w_bin !== 5'h08)  begin errs++; $display("FAIL wrap_final_bin: got %h expected 08", w_bin); end
    vecs++; if (w_addr !== 4'h8)  begin errs++; $display("FAIL wrap_final_addr: got %h expected 8", w_addr); end
    vecs++; if (w_level !== 5'd5) begin errs++; $display("FAIL wrap_final_level: got %0d expected 5", w_level); end
  endtask

  task automatic test_read_side();
    r_inc  = 1'b0;
    r_peer = 5'h02;
    #1;
    vecs++; if (r_flag !== 1'b1) begin errs++; $display("FAIL rd_flag_edge0: got %b expected 1", r_flag); end
    tick();
    vecs++; if (r_flag !== 1'b1) begin errs++; $display("FAIL rd_flag_edge1: got %b expected 1", r_flag); end
    tick();
    vecs++; if (r_flag !== 1'b0)   begin errs++; $display("FAIL rd_flag_edge2: got %b expected 0", r_flag); end
    vecs++; if (r_level !== 5'd3)  begin errs++; $display("FAIL rd_level3: got %0d expected 3", r_level); end
    vecs++; if (r_almost !== 1'b0) begin errs++; $display("FAIL rd_almost_lvl3: got %b expected 0", r_almost); end
    for (int k = 1; k <= 3; k++) begin
      r_inc = 1'b1;
      #1;
      vecs++; if (r_inc_ok !== 1'b1) begin errs++; $display("FAIL rd_inc_ok_%0d: got %b expected 1", k, r_inc_ok); end
      tick();
      vecs++; if (r_level !== 5'(3 - k)) begin errs++; $display("FAIL rd_level_%0d: got %0d expected %0d", k, r_level, 3 - k); end
    end
    r_inc = 1'b0;
    vecs++; if (r_flag !== 1'b1)   begin errs++; $display("FAIL rd_empty: got %b expected 1", r_flag); end
    vecs++; if (r_almost !== 1'b1) begin errs++; $display("FAIL rd_almost_lvl0: got %b expected 1", r_almost); end
    vecs++; if (r_bin !== 5'h03)   begin errs++; $display("FAIL rd_bin: got %h expected 03", r_bin); end
    vecs++; if (r_gray !== 5'h02)  begin errs++; $display("FAIL rd_gray: got %h expected 02", r_gray); end
    r_inc = 1'b1;
    #1;
    vecs++; if (r_inc_ok !== 1'b0) begin errs++; $display("FAIL rd_empty_inc_ok: got %b expected 0", r_inc_ok); end
    tick();
    r_inc = 1'b0;
    vecs++; if (r_ovf !== 1'b1)  begin errs++; $display("FAIL rd_ovf: got %b expected 1", r_ovf); end
    vecs++; if (r_bin !== 5'h03) begin errs++; $display("FAIL rd_hold_bin: got %h expected 03", r_bin); end
  endtask

  // Almost-empty boundary at level 1 on the read side
  task automatic test_almost_empty();
    r_peer = enc5(5'h05);
    tick();
    tick();
    vecs++; if (r_level !== 5'd2)  begin errs++; $display("FAIL ae_level2: got %0d expected 2", r_level); end
    vecs++; if (r_almost !== 1'b0) begin errs++; $display("FAIL ae_lvl2: got %b expected 0", r_almost); end
    r_inc = 1'b1;
    tick();
    r_inc = 1'b0;
    vecs++; if (r_level !== 5'd1)  begin errs++; $display("FAIL ae_level1: got %0d expected 1", r_level); end
    vecs++; if (r_almost !== 1'b1) begin errs++; $display("FAIL ae_lvl1: got %b expected 1", r_almost); end
    vecs++; if (r_flag !== 1'b0)   begin errs++; $display("FAIL ae_flag_lvl1: got %b expected 0", r_flag); end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_full_almost();
    test_clear_priority();
    test_wrap();
    test_read_side();
    test_almost_empty();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
